// File: rtl/scarv_cop_dispatch.sv
// -----------------------------------------------------------------------------
// scarv_cop_dispatch
//
// CPU-side dispatch unit for the SCARV coprocessor interface. It accepts one
// decoded coprocessor instruction at a time from the host pipeline, issues it
// to the COP over the cpu_insn_req / cop_insn_ack handshake, collects the
// result over the cop_insn_rsp / cpu_insn_ack handshake and presents it to
// the host as a writeback record. A response watchdog can abort an
// instruction that never answers and report TIMEOUT_RESULT in its place.
//
// Parameters
//   TIMEOUT         cycles allowed in WAIT before abort (0 = no watchdog, <=255)
//   TIMEOUT_RESULT  wb_result code reported when the watchdog fires
//
// Ports
//   g_clk, g_resetn            clock, asynchronous active-low reset
//   issue_valid/issue_ready    host instruction handshake
//   issue_enc, issue_rs1       encoded instruction and RS1 operand
//   issue_abort                host cancels the in-flight instruction
//   wb_valid/wb_ready          writeback record handshake
//   wb_wen/addr/data/result    writeback record fields
//   cpu_insn_req/cop_insn_ack  instruction request to the COP
//   cpu_abort_req              one-cycle abort pulse to the COP
//   cpu_insn_enc, cpu_rs1      instruction and operand held for the COP
//   cop_wen/waddr/wdata/result COP result fields
//   cop_insn_rsp/cpu_insn_ack  COP result handshake
// -----------------------------------------------------------------------------
module scarv_cop_dispatch #(
  parameter int unsigned TIMEOUT        = 255,
  parameter logic [2:0]  TIMEOUT_RESULT = 3'b111
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] issue_enc,
  input  logic [31:0] issue_rs1,
  input  logic        issue_abort,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_wen,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [2:0]  wb_result,
  output logic        cpu_insn_req,
  input  logic        cop_insn_ack,
  output logic        cpu_abort_req,
  output logic [31:0] cpu_insn_enc,
  output logic [31:0] cpu_rs1,
  input  logic        cop_wen,
  input  logic [4:0]  cop_waddr,
  input  logic [31:0] cop_wdata,
  input  logic [2:0]  cop_result,
  input  logic        cop_insn_rsp,
  output logic        cpu_insn_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic       WD_EN   = (TIMEOUT != 0);
  // Counter value of the last WAIT cycle allowed before the watchdog fires.
  localparam logic [7:0] WD_LAST = WD_EN ? 8'(TIMEOUT - 1) : 8'd0;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        abort_q, abort_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] enc_q, enc_d;
  logic [31:0] rs1_q, rs1_d;
  logic        wb_wen_q, wb_wen_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [2:0]  wb_result_q, wb_result_d;

  logic accept;
  logic wd_fire;

  assign issue_ready  = (state_q == S_IDLE) || ((state_q == S_WB) && wb_ready);
  assign cpu_insn_ack = (state_q == S_WAIT);
  assign accept       = issue_valid && issue_ready;
  assign wd_fire      = WD_EN && (cnt_q == WD_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = 1'b0;
    enc_d       = enc_q;
    rs1_d       = rs1_q;
    wb_wen_d    = wb_wen_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_result_d = wb_result_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          enc_d   = issue_enc;
          rs1_d   = issue_rs1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (cop_insn_ack) begin
          // Once the COP has taken the instruction, cancelling needs an
          // explicit abort so that it never answers.
          if (issue_abort) begin
            abort_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_WAIT;
          end
        end else if (issue_abort) begin
          state_d = S_IDLE;
        end
      end

      S_WAIT: begin
        // A response always wins over a host abort or the watchdog.
        if (cop_insn_rsp) begin
          wb_wen_d    = cop_wen;
          wb_addr_d   = cop_waddr;
          wb_data_d   = cop_wdata;
          wb_result_d = cop_result;
          state_d     = S_WB;
        end else if (issue_abort) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (wd_fire) begin
          abort_d     = 1'b1;
          wb_wen_d    = 1'b0;
          wb_addr_d   = 5'd0;
          wb_data_d   = 32'd0;
          wb_result_d = TIMEOUT_RESULT;
          state_d     = S_WB;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end

      S_WB: begin
        if (wb_ready) begin
          if (accept) begin
            enc_d   = issue_enc;
            rs1_d   = issue_rs1;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    req_d      = (state_d == S_REQ);
    wb_valid_d = (state_d == S_WB);
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      req_q       <= 1'b0;
      abort_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      enc_q       <= 32'd0;
      rs1_q       <= 32'd0;
      wb_wen_q    <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= 32'd0;
      wb_result_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      abort_q     <= abort_d;
      wb_valid_q  <= wb_valid_d;
      enc_q       <= enc_d;
      rs1_q       <= rs1_d;
      wb_wen_q    <= wb_wen_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      wb_result_q <= wb_result_d;
    end
  end

  assign cpu_insn_req  = req_q;
  assign cpu_abort_req = abort_q;
  assign cpu_insn_enc  = enc_q;
  assign cpu_rs1       = rs1_q;
  assign wb_valid      = wb_valid_q;
  assign wb_wen        = wb_wen_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign wb_result     = wb_result_q;

endmodule

// File: tb/tb_scarv_cop_dispatch.sv
// -----------------------------------------------------------------------------
// tb_scarv_cop_dispatch
//
// Self-checking bench for scarv_cop_dispatch (TIMEOUT=4). Directed sequences
// cover reset, basic issue/writeback, request stall, aborts and the watchdog;
// a randomized back-to-back stream is checked against queues of expected
// instructions and writeback records produced by the bench-side COP.
// -----------------------------------------------------------------------------
module tb_scarv_cop_dispatch;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        issue_valid, issue_ready, issue_abort;
  logic [31:0] issue_enc, issue_rs1;
  logic        wb_valid, wb_ready, wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  wb_result;
  logic        cpu_insn_req, cop_insn_ack, cpu_abort_req, cpu_insn_ack;
  logic [31:0] cpu_insn_enc, cpu_rs1;
  logic        cop_wen, cop_insn_rsp;
  logic [4:0]  cop_waddr;
  logic [31:0] cop_wdata;
  logic [2:0]  cop_result;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  res;
  } rec_t;

  rec_t        exp_wb[$];
  logic [63:0] exp_iss[$];

  always #5 g_clk = ~g_clk;

  scarv_cop_dispatch #(
    .TIMEOUT        (4),
    .TIMEOUT_RESULT (3'b111)
  ) dut (
    .g_clk         (g_clk),
    .g_resetn      (g_resetn),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_enc     (issue_enc),
    .issue_rs1     (issue_rs1),
    .issue_abort   (issue_abort),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_wen        (wb_wen),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_result     (wb_result),
    .cpu_insn_req  (cpu_insn_req),
    .cop_insn_ack  (cop_insn_ack),
    .cpu_abort_req (cpu_abort_req),
    .cpu_insn_enc  (cpu_insn_enc),
    .cpu_rs1       (cpu_rs1),
    .cop_wen       (cop_wen),
    .cop_waddr     (cop_waddr),
    .cop_wdata     (cop_wdata),
    .cop_result    (cop_result),
    .cop_insn_rsp  (cop_insn_rsp),
    .cpu_insn_ack  (cpu_insn_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] e, input logic [31:0] r);
    issue_valid = 1'b1;
    issue_enc   = e;
    issue_rs1   = r;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic respond(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [2:0] res);
    cop_insn_rsp = 1'b1;
    cop_wen      = w;
    cop_waddr    = a;
    cop_wdata    = d;
    cop_result   = res;
    tick();
    cop_insn_rsp = 1'b0;
    cop_wen      = 1'b0;
    cop_waddr    = 5'h1F;
    cop_wdata    = $urandom;
    cop_result   = 3'b101;
  endtask

  task automatic ack();
    cop_insn_ack = 1'b1;
    tick();
    cop_insn_ack = 1'b0;
  endtask

  task automatic drain_wb();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_issue_ready"}, 64'(issue_ready), 64'd1);
    chk({tag, "_wb_valid"},    64'(wb_valid), 64'd0);
    chk({tag, "_req"},         64'(cpu_insn_req), 64'd0);
    chk({tag, "_abort"},       64'(cpu_abort_req), 64'd0);
    chk({tag, "_insn_ack"},    64'(cpu_insn_ack), 64'd0);
    chk({tag, "_enc_rs1"},     {cpu_insn_enc, cpu_rs1}, 64'd0);
    chk({tag, "_wb_fields"},   64'({wb_wen, wb_addr, wb_data, wb_result}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    logic [31:0] e, r;
    rec_t rec, got;
    logic [63:0] iss;

    g_resetn     = 1'b0;
    issue_valid  = 1'b0;
    issue_enc    = 32'd0;
    issue_rs1    = 32'd0;
    issue_abort  = 1'b0;
    wb_ready     = 1'b0;
    cop_insn_ack = 1'b0;
    cop_insn_rsp = 1'b0;
    cop_wen      = 1'b0;
    cop_waddr    = 5'd0;
    cop_wdata    = 32'd0;
    cop_result   = 3'd0;

    #1;
    check_reset_outputs("rst");
    tick();
    tick();
    g_resetn = 1'b1;
    tick();

    // Basic issue and writeback
    issue(32'h0000_402B, 32'h1234_5678);
    chk("b_req", 64'(cpu_insn_req), 64'd1);
    chk("b_enc_rs1", {cpu_insn_enc, cpu_rs1}, 64'h0000_402B_1234_5678);
    chk("b_issue_ready", 64'(issue_ready), 64'd0);
    ack();
    chk("b_insn_ack", 64'(cpu_insn_ack), 64'd1);
    chk("b_req_low", 64'(cpu_insn_req), 64'd0);
    tick();
    tick();
    respond(1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0);
    chk("b_wb_valid", 64'(wb_valid), 64'd1);
    chk("b_wb_rec", 64'({wb_wen, wb_addr, wb_data, wb_result}),
        64'({1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0}));
    chk("b_insn_ack_low", 64'(cpu_insn_ack), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b_hold_valid", 64'(wb_valid), 64'd1);
      chk("b_hold_rec", 64'({wb_wen, wb_addr, wb_data, wb_result}),
          64'({1'b1, 5'd5, 32'hDEAD_BEEF, 3'd0}));
    end
    chk("b_wb_ready_gate", 64'(issue_ready), 64'd0);
    wb_ready = 1'b1;
    #1;
    chk("b_ready_in_wb", 64'(issue_ready), 64'd1);
    tick();
    wb_ready = 1'b0;
    chk("b_wb_done", 64'(wb_valid), 64'd0);

    // Request stall: new issue attempts must not disturb the held request
    issue(32'hCAFE_0001, 32'h0BAD_F00D);
    issue_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue_enc = $urandom;
      issue_rs1 = $urandom;
      #1;
      chk("s_issue_ready", 64'(issue_ready), 64'd0);
      tick();
      chk("s_req", 64'(cpu_insn_req), 64'd1);
      chk("s_enc_rs1", {cpu_insn_enc, cpu_rs1}, 64'hCAFE_0001_0BAD_F00D);
    end
    issue_valid = 1'b0;
    ack();
    respond(1'b0, 5'd1, 32'h1, 3'd1);
    chk("s_wb_rec", 64'({wb_wen, wb_addr, wb_data, wb_result}), 64'({1'b0, 5'd1, 32'h1, 3'd1}));
    drain_wb();

    // Abort in REQ without ack
    issue(32'h1111_1111, 32'h2222_2222);
    issue_abort = 1'b1;
    tick();
    issue_abort = 1'b0;
    chk("ar_req", 64'(cpu_insn_req), 64'd0);
    chk("ar_abort", 64'(cpu_abort_req), 64'd0);
    chk("ar_idle", 64'(issue_ready), 64'd1);
    tick();
    chk("ar_abort2", 64'(cpu_abort_req), 64'd0);
    chk("ar_no_wb", 64'(wb_valid), 64'd0);

    // Abort in WAIT
    issue(32'h3333_3333, 32'h4444_4444);
    ack();
    tick();
    issue_abort = 1'b1;
    tick();
    issue_abort = 1'b0;
    chk("aw_abort", 64'(cpu_abort_req), 64'd1);
    chk("aw_no_wb", 64'(wb_valid), 64'd0);
    chk("aw_idle", 64'(issue_ready), 64'd1);
    tick();
    chk("aw_abort_pulse", 64'(cpu_abort_req), 64'd0);
    chk("aw_no_wb2", 64'(wb_valid), 64'd0);

    // Abort coincident with response: response wins
    issue(32'h5555_5555, 32'h6666_6666);
    ack();
    issue_abort = 1'b1;
    respond(1'b1, 5'd9, 32'h0123_4567, 3'd2);
    issue_abort = 1'b0;
    chk("ac_wb_valid", 64'(wb_valid), 64'd1);
    chk("ac_no_abort", 64'(cpu_abort_req), 64'd0);
    chk("ac_wb_rec", 64'({wb_wen, wb_addr, wb_data, wb_result}),
        64'({1'b1, 5'd9, 32'h0123_4567, 3'd2}));
    drain_wb();

    // Watchdog expiry: writeback must appear 5 cycles after the ack cycle
    issue(32'h7777_7777, 32'h8888_8888);
    ack();
    n = 1;
    while (!wb_valid && n < 20) begin
      chk("wd_early_abort", 64'(cpu_abort_req), 64'd0);
      tick();
      n++;
    end
    chk("wd_latency", 64'(n), 64'd5);
    chk("wd_wb_valid", 64'(wb_valid), 64'd1);
    chk("wd_abort", 64'(cpu_abort_req), 64'd1);
    chk("wd_wb_rec", 64'({wb_wen, wb_addr, wb_data, wb_result}), 64'({1'b0, 5'd0, 32'd0, 3'b111}));
    tick();
    chk("wd_abort_pulse", 64'(cpu_abort_req), 64'd0);
    drain_wb();

    // Response in the watchdog firing cycle wins
    issue(32'h9999_9999, 32'hAAAA_AAAA);
    ack();
    tick();
    tick();
    tick();
    respond(1'b1, 5'd17, 32'h5A5A_A5A5, 3'd2);
    chk("wr_wb_valid", 64'(wb_valid), 64'd1);
    chk("wr_no_abort", 64'(cpu_abort_req), 64'd0);
    chk("wr_wb_rec", 64'({wb_wen, wb_addr, wb_data, wb_result}),
        64'({1'b1, 5'd17, 32'h5A5A_A5A5, 3'd2}));
    drain_wb();

    // Back-to-back random stream with wb_ready held high
    wb_ready    = 1'b1;
    e           = $urandom;
    r           = $urandom;
    exp_iss.push_back({e, r});
    issue_valid = 1'b1;
    issue_enc   = e;
    issue_rs1   = r;
    tick();
    for (int i = 0; i < 20; i++) begin
      int da, dr;
      da = $urandom_range(0, 3);
      dr = $urandom_range(0, 3);
      iss = exp_iss.pop_front();
      chk("bb_req", 64'(cpu_insn_req), 64'd1);
      chk("bb_enc_rs1", {cpu_insn_enc, cpu_rs1}, iss);
      if (i < 19) begin
        e         = $urandom;
        r         = $urandom;
        exp_iss.push_back({e, r});
        issue_enc = e;
        issue_rs1 = r;
      end else begin
        issue_valid = 1'b0;
      end
      repeat (da) tick();
      ack();
      repeat (dr) tick();
      rec.wen  = 1'($urandom);
      rec.addr = 5'($urandom);
      rec.data = $urandom;
      rec.res  = 3'($urandom_range(0, 6));
      exp_wb.push_back(rec);
      respond(rec.wen, rec.addr, rec.data, rec.res);
      chk("bb_wb_valid", 64'(wb_valid), 64'd1);
      got = {wb_wen, wb_addr, wb_data, wb_result};
      chk("bb_wb_rec", 64'(got), 64'(exp_wb.pop_front()));
      tick();
    end
    chk("bb_end_idle", 64'(issue_ready), 64'd1);
    chk("bb_end_wb", 64'(wb_valid), 64'd0);
    chk("bb_all_consumed", 64'(exp_wb.size() + exp_iss.size()), 64'd0);
    wb_ready = 1'b0;

    // Asynchronous reset in the middle of WAIT
    issue(32'hFEED_FACE, 32'h0DDB_A11D);
    ack();
    #2;
    g_resetn = 1'b0;
    #1;
    check_reset_outputs("arst");
    tick();
    check_reset_outputs("arst_hold");
    g_resetn = 1'b1;
    tick();
    chk("arst_after_abort", 64'(cpu_abort_req), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/scarv_cop_dispatch.md
# scarv_cop_dispatch

CPU-side dispatch unit for the SCARV coprocessor interface; sits directly upstream of `scarv_cop_top`.
- Accepts one decoded coprocessor instruction at a time from the host pipeline and drives the `cpu_insn_req`/`cop_insn_ack` issue handshake.
- Collects the result through the `cop_insn_rsp`/`cpu_insn_ack` handshake and presents it to host GPR writeback.
- Enforces an optional response watchdog with abort.

## Interface
- `TIMEOUT`, 255: cycles allowed in WAIT before abort; 0 disables the watchdog; max 255.
- `TIMEOUT_RESULT`, 3'b111: `wb_result` code reported on watchdog expiry.
- `g_clk`  in  1  global clock.
- `g_resetn`  in  1  reset; one clock, asynchronous and active-low.
- `issue_valid`  in  1  host presents an instruction.
- `issue_ready`  out  1  dispatch can accept an instruction.
- `issue_enc`  in  32  encoded instruction.
- `issue_rs1`  in  32  RS1 operand.
- `issue_abort`  in  1  host cancels the in-flight instruction.
- `wb_valid`  out  1  writeback record valid.
- `wb_ready`  in  1  host consumes the writeback record.
- `wb_wen`, `wb_addr`, `wb_data`, `wb_result`  out  1/5/32/3  writeback record fields.
- `cpu_insn_req`  out  1  instruction request to the COP.
- `cop_insn_ack`  in  1  COP accepts the request.
- `cpu_abort_req`  out  1  one-cycle abort pulse to the COP.
- `cpu_insn_enc`, `cpu_rs1`  out  32/32  held instruction and operand.
- `cop_wen`, `cop_waddr`, `cop_wdata`, `cop_result`  in  1/5/32/3  COP result fields.
- `cop_insn_rsp`  in  1  COP result valid.
- `cpu_insn_ack`  out  1  result accepted by dispatch.

## Operation
- **States:** IDLE, REQ, WAIT, WB; one outstanding instruction only.
- **Issue acceptance:**
  - `issue_ready` = IDLE, or (WB && `wb_ready`).
  - Acceptance is `issue_valid && issue_ready`.
  - On acceptance: `issue_enc`/`issue_rs1` are registered into `cpu_insn_enc`/`cpu_rs1`, and the state goes to REQ.
- **REQ:**
  - `cpu_insn_req`=1.
  - Enc and rs1 are held stable until `cop_insn_ack`; then the state goes to WAIT and the watchdog counter clears to 0.
- **WAIT:**
  - `cpu_insn_ack`=1 (combinational on state).
  - On `cop_insn_rsp`, the `cop_*` result fields are captured into the `wb_*` registers and the state goes to WB.
  - The counter increments each WAIT cycle without a response.
- **WB:**
  - `wb_valid`=1, with the record held stable until `wb_ready`.
  - On `wb_ready`: go to REQ if a new issue is accepted in the same cycle, else IDLE.
- **Abort contract:** the COP never raises `cop_insn_rsp` for an instruction after receiving `cpu_abort_req`.
- **`issue_abort` by state:**
  - In REQ with no `cop_insn_ack` that cycle: drop `cpu_insn_req`, go IDLE, no `cpu_abort_req`, no writeback.
  - In REQ with `cop_insn_ack` the same cycle, or in WAIT without `cop_insn_rsp`: pulse `cpu_abort_req` for 1 cycle, go IDLE, no writeback.
  - In WAIT with `cop_insn_rsp` the same cycle: the response wins; it is captured, no abort is issued, and the state goes to WB.
  - In IDLE or WB: ignored.
- **Watchdog:**
  - Fires when `TIMEOUT`!=0 and the counter equals `TIMEOUT`-1 with no `cop_insn_rsp`.
  - On firing: pulse `cpu_abort_req`, load `wb_result`=`TIMEOUT_RESULT`, `wb_wen`=0, `wb_addr`=0, `wb_data`=0, and go to WB.
  - A response in the firing cycle wins over the timeout.
- **Counter:** 8 bits, saturating; only meaningful in WAIT.

## Timing
- **Reset values:** all outputs 0 except `issue_ready`=1. State is IDLE and all registers are cleared.
- **Reset during any state:** returns to IDLE on assertion with no handshake completion. The in-flight instruction is lost and no `cpu_abort_req` is issued.
- **Minimum latency:**
  - Issue accepted at edge 0; `cpu_insn_req` high in cycle 1.
  - With ack in cycle 1 and rsp in cycle 2, `wb_valid` is high in cycle 3.
- **Register behaviour:**
  - `cpu_insn_req`, `cpu_abort_req` and the `wb_*` outputs are registered.
  - `cpu_insn_ack` and `issue_ready` are decoded from state; `issue_ready` also depends on `wb_ready`.
- **Back-to-back:** WB→REQ with no idle cycle when `wb_ready` and `issue_valid` are both high.
- **Watchdog timing:** the timeout writeback appears `TIMEOUT`+1 cycles after ack.

## Test plan
- **Basic issue and writeback:** issue enc=0x0000_402B, rs1=0x1234_5678; ack in 1 cycle; rsp with wen=1, waddr=5, wdata=0xDEAD_BEEF, result=0 after 3 cycles.
  - `wb_valid` appears 1 cycle after rsp with those values.
  - Holding `wb_ready`=0 for 4 cycles leaves the record unchanged.
- **Request stall:** ack withheld for 6 cycles.
  - `cpu_insn_req` stays high and `cpu_insn_enc`/`cpu_rs1` stay constant.
  - `issue_ready`=0 throughout.
- **Aborts:**
  - `issue_abort` in REQ without ack → IDLE, no `cpu_abort_req`, no writeback.
  - `issue_abort` in WAIT → one-cycle `cpu_abort_req`, no writeback.
  - `issue_abort` coincident with rsp → writeback produced, no abort pulse.
- **Watchdog:** `TIMEOUT`=4, no rsp.
  - `cpu_abort_req` pulses and `wb_result`=3'b111 with `wb_wen`=0, exactly 5 cycles after ack.
  - Repeat with rsp arriving in the firing cycle: the normal result is reported.
- **Back-to-back stream:** 20 instructions with random ack/rsp delays of 0-3 cycles and `wb_ready` held high.
  - Writebacks arrive in order, one per instruction, WB→REQ with no gap.
  - Async reset mid-WAIT returns all outputs to their reset values immediately.
